// File: rtl/mdu_pipe.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed when the op is accepted and held in pending
// registers. HI/LO are updated on the last busy cycle, so the new values
// are visible in the first cycle that busy is low.
module mdu_pipe #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mdu_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   a_abs, b_abs, b_safe, bu_safe;
  logic [WIDTH-1:0]   qs_mag, rs_mag, qs, rs, qu, ru;
  logic               b_zero;

  // Full-width products and quotients from the current operands.
  // The signed divide works on magnitudes; the overflow case (most-negative
  // divided by -1) yields LO=A and HI=0 naturally from the magnitude path.
  always_comb begin
    prod_s  = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
    prod_u  = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    b_zero  = (B == '0);
    a_abs   = A[WIDTH-1] ? (~A + 1'b1) : A;
    b_abs   = B[WIDTH-1] ? (~B + 1'b1) : B;
    b_safe  = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_abs;
    bu_safe = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : B;
    qs_mag  = a_abs / b_safe;
    rs_mag  = a_abs % b_safe;
    qs      = (A[WIDTH-1] ^ B[WIDTH-1]) ? (~qs_mag + 1'b1) : qs_mag;
    rs      = A[WIDTH-1] ? (~rs_mag + 1'b1) : rs_mag;
    qu      = A / bu_safe;
    ru      = A % bu_safe;
  end

  // Next-state logic: accept ops in IDLE, count down in RUN, commit at the end.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (mdu_op)
            OP_MULT: begin
              pend_hi_d = prod_s[2*WIDTH-1:WIDTH];
              pend_lo_d = prod_s[WIDTH-1:0];
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES);
              busy_d    = 1'b1;
              state_d   = S_RUN;
            end
            OP_MULTU: begin
              pend_hi_d = prod_u[2*WIDTH-1:WIDTH];
              pend_lo_d = prod_u[WIDTH-1:0];
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES);
              busy_d    = 1'b1;
              state_d   = S_RUN;
            end
            OP_DIV: begin
              pend_hi_d = rs;
              pend_lo_d = qs;
              pend_wr_d = !b_zero;
              cnt_d     = CNT_W'(DIV_CYCLES);
              busy_d    = 1'b1;
              state_d   = S_RUN;
            end
            OP_DIVU: begin
              pend_hi_d = ru;
              pend_lo_d = qu;
              pend_wr_d = !b_zero;
              cnt_d     = CNT_W'(DIV_CYCLES);
              busy_d    = 1'b1;
              state_d   = S_RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset discards any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_pipe.sv
// Directed self-checking bench for mdu_pipe (WIDTH=32, MULT=5, DIV=10).
module tb_mdu_pipe;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks;
  int failures;
  int n;

  mdu_pipe #(
    .WIDTH      (32),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mdu_op(mdu_op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op for a single cycle.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    mdu_op = op;
    A      = a;
    B      = b;
    step();
    start  = 1'b0;
    mdu_op = 3'd7;
  endtask

  // Count cycles with busy high, bounded.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      step();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    mdu_op   = 3'd7;
    A        = '0;
    B        = '0;
    step();
    step();
    reset = 1'b0;
    chk("reset_hi", HI, 32'h0);
    chk("reset_lo", LO, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);

    issue(3'd4, 32'h12345678, 32'h0);
    chk("mthi_hi", HI, 32'h12345678);
    chk("mthi_busy", {31'b0, busy}, 32'h0);
    issue(3'd5, 32'hCAFEBABE, 32'h0);
    chk("mtlo_lo", LO, 32'hCAFEBABE);
    chk("mtlo_hi_kept", HI, 32'h12345678);
    chk("mtlo_busy", {31'b0, busy}, 32'h0);

    issue(3'd6, 32'h11111111, 32'h0);
    issue(3'd7, 32'h22222222, 32'h0);
    chk("nop_hi", HI, 32'h12345678);
    chk("nop_lo", LO, 32'hCAFEBABE);
    chk("nop_busy", {31'b0, busy}, 32'h0);

    issue(3'd0, 32'hFFFFFFFE, 32'h00000003);
    wait_idle(n);
    chk("mult_cycles", 32'(n), 32'd5);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFA);

    issue(3'd1, 32'hFFFFFFFE, 32'h00000003);
    wait_idle(n);
    chk("multu_cycles", 32'(n), 32'd5);
    chk("multu_hi", HI, 32'h00000002);
    chk("multu_lo", LO, 32'hFFFFFFFA);

    issue(3'd2, 32'hFFFFFFF9, 32'h00000002);
    wait_idle(n);
    chk("div_cycles", 32'(n), 32'd10);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);

    issue(3'd2, 32'h00000007, 32'hFFFFFFFE);
    wait_idle(n);
    chk("div_pos_neg_lo", LO, 32'hFFFFFFFD);
    chk("div_pos_neg_hi", HI, 32'h00000001);

    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    chk("div_ovf_lo", LO, 32'h80000000);
    chk("div_ovf_hi", HI, 32'h00000000);

    issue(3'd3, 32'hFFFFFFF9, 32'h00000002);
    wait_idle(n);
    chk("divu_cycles", 32'(n), 32'd10);
    chk("divu_lo", LO, 32'h7FFFFFFC);
    chk("divu_hi", HI, 32'h00000001);

    issue(3'd4, 32'h00000005, 32'h0);
    issue(3'd5, 32'h00000006, 32'h0);
    issue(3'd3, 32'h00000007, 32'h00000000);
    wait_idle(n);
    chk("divz_cycles", 32'(n), 32'd10);
    chk("divz_hi", HI, 32'h00000005);
    chk("divz_lo", LO, 32'h00000006);

    // Starts while busy must be ignored entirely.
    issue(3'd0, 32'h00000004, 32'h00000005);
    issue(3'd5, 32'hDEADBEEF, 32'h0);
    issue(3'd0, 32'h00000007, 32'h00000007);
    wait_idle(n);
    chk("ign_cycles", 32'(n + 2), 32'd5);
    chk("ign_hi", HI, 32'h00000000);
    chk("ign_lo", LO, 32'h00000014);
    step();
    chk("ign_no_restart", {31'b0, busy}, 32'h0);

    // Reset during the third busy cycle aborts the MULT.
    issue(3'd0, 32'h00000010, 32'h00000010);
    chk("abort_busy1", {31'b0, busy}, 32'h1);
    issue(3'd5, 32'hDEADBEEF, 32'h0);
    issue(3'd0, 32'h00000003, 32'h00000003);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_hi", HI, 32'h0);
    chk("abort_lo", LO, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    for (int i = 0; i < 10; i++) step();
    chk("abort_late_hi", HI, 32'h0);
    chk("abort_late_lo", LO, 32'h0);
    chk("abort_late_busy", {31'b0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_pipe.md
Name: mdu_pipe

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage beside the single-cycle ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO and exposes a busy flag so the hazard unit can stall MFHI/MFLO and further MDU instructions.
- Extends the ALU family with configurable width, configurable latency and a HI/LO state machine.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1).
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  EX-stage instruction is a valid MDU op this cycle.
- mdu_op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op.
- A  input  WIDTH  rs operand.
- B  input  WIDTH  rt operand.
- busy  output  1  operation in flight.
- HI  output  WIDTH  architectural HI register.
- LO  output  WIDTH  architectural LO register.

Behaviour:
- Reset (sync, active-high):
  - HI=0, LO=0, busy=0, counter=0, state IDLE.
  - Reset mid-operation aborts the op; the pending result is discarded.
- States: IDLE, RUN.
- IDLE, start=1, mdu_op in {0..3}:
  - At the edge, compute the full result from A/B and latch it into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 from the next cycle.
- IDLE, start=1, mdu_op=4: HI←A at the edge, no busy. mdu_op=5: LO←A likewise.
- RUN:
  - Counter decrements each cycle.
  - When counter==1: HI/LO←pending at that edge; busy=0 and state IDLE from the next cycle.
  - Total busy high = exactly N cycles. New HI/LO are visible in the first cycle busy=0.
- start=1 while busy=1: ignored entirely, including MTHI/MTLO. The hazard unit must stall; the bench checks HI/LO are unaffected.
- busy is a registered output; no combinational path from start.
- MULT: signed 2·WIDTH product; HI=upper WIDTH bits, LO=lower.
- MULTU: unsigned 2·WIDTH product; HI=upper WIDTH bits, LO=lower.
- DIV:
  - Signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - Overflow (A=most-negative, B=-1): LO=A, HI=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (B=0, DIV or DIVU): busy still runs DIV_CYCLES; HI/LO keep their prior values at completion.
- mdu_op 6/7 with start=1: no effect.

Test Plan:
- Reset, then MTHI A=0x12345678 (IDLE) → next cycle HI=0x12345678, busy stays 0; MTLO A=0xCAFEBABE → LO=0xCAFEBABE.
- MULT A=0xFFFFFFFE (-2), B=0x00000003 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- DIV A=0xFFFFFFF9 (-7), B=2 → busy high exactly 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU A=7, B=0 with HI=5, LO=6 beforehand → busy high 10 cycles; HI=5, LO=6 unchanged.
- MULT started, then MTLO and a second MULT issued while busy → both ignored; assert reset in cycle 3 of the first MULT → next cycle HI=LO=0, busy=0, and no later write occurs.
